// File: rtl/ziposoc_pkg.sv
// Shared constants for the ziposoc data-bus blocks: the arbiter FSM encoding
// and the bus access size and direction codes.
package ziposoc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } arb_state_t;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/data_bus_arbiter_arb_pick.sv
// Combinational grant selection between two requesters. A lone requester
// always wins. On a tie the winner is the one that was not the last owner.
module arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic owner
);

  always_comb begin
    owner = 1'b0;
    if (req0 && req1)
      owner = ~last_owner;
    else if (req1)
      owner = 1'b1;
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master arbiter in front of the shared data bus. Each transaction goes
// IDLE -> ACCESS (ACCESS_CYCLES) -> ACK.
// Define ARB_ROUND_ROBIN_EN to alternate on ties; otherwise m0 has fixed priority.
module data_bus_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 8,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_rw,
  input  logic [1:0]        m0_len,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_rw,
  input  logic [1:0]        m1_len,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              bus_rw,
  output logic [1:0]        bus_len,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_write,
  input  logic [DATA_W-1:0] bus_read,
  input  logic              bus_exception
);

  import ziposoc_pkg::*;

  localparam int CNT_W = $clog2(ACCESS_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  arb_state_t       state;
  logic             owner;
  logic             pick;
  logic             prio_last;
  logic [CNT_W-1:0] cnt;

  // The tie-break history only exists in the round-robin build; fixed priority
  // presents a constant "m1 was last" so that m0 always wins a tie.
`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;

  always_ff @(posedge clk) begin
    if (!rst_n)
      last_owner <= 1'b1;
    else if (state == ST_IDLE && (m0_req || m1_req))
      last_owner <= pick;
  end

  assign prio_last = last_owner;
`else
  assign prio_last = 1'b1;
`endif

  arb_pick u_pick (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_owner (prio_last),
    .owner      (pick)
  );

  // The bus command registers double as the latched command: they are loaded
  // on the granting edge and zeroed when the access phase ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner     <= 1'b0;
      cnt       <= '0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      bus_rw    <= RW_READ;
      bus_len   <= LEN_BYTE;
      bus_addr  <= '0;
      bus_write <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            state     <= ST_ACCESS;
            owner     <= pick;
            cnt       <= '0;
            m0_gnt    <= ~pick;
            m1_gnt    <= pick;
            bus_rw    <= pick ? m1_rw    : m0_rw;
            bus_len   <= pick ? m1_len   : m0_len;
            bus_addr  <= pick ? m1_addr  : m0_addr;
            bus_write <= pick ? m1_wdata : m0_wdata;
          end
        end
        ST_ACCESS: begin
          if (cnt == CNT_LAST) begin
            state     <= ST_ACK;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            bus_rw    <= RW_READ;
            bus_len   <= LEN_BYTE;
            bus_addr  <= '0;
            bus_write <= '0;
            if (owner) begin
              m1_ack   <= 1'b1;
              m1_rdata <= bus_read;
              m1_err   <= bus_exception;
            end else begin
              m0_ack   <= 1'b1;
              m0_rdata <= bus_read;
              m0_err   <= bus_exception;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ACK: begin
          state  <= ST_IDLE;
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench for data_bus_arbiter with a 3-cycle access; follows the
// arbitration policy selected by ARB_ROUND_ROBIN_EN.
module tb_data_bus_arbiter;

  import ziposoc_pkg::*;

  localparam int AC = 3;

  typedef struct packed {
    logic        owner;
    logic        rw;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m1_req;
  logic        cmd_rw    [2];
  logic [1:0]  cmd_len   [2];
  logic [31:0] cmd_addr  [2];
  logic [7:0]  cmd_wdata [2];
  logic        m0_gnt, m0_ack, m0_err, m1_gnt, m1_ack, m1_err;
  logic [7:0]  m0_rdata, m1_rdata;
  logic        bus_rw;
  logic [1:0]  bus_len;
  logic [31:0] bus_addr;
  logic [7:0]  bus_write, bus_read;
  logic        bus_exception;
  logic        exc_inject;
  logic        mon_en;
  logic        model_last;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [7:0]  exp_rdata [2];
  logic        exp_err   [2];
  int          gnt_cnt;
  logic        prev_ack;
  int          total;
  int          bad;

  // The bus responder returns a value derived from the address it was given.
  assign bus_read      = bus_addr[7:0] ^ 8'hB5;
  assign bus_exception = exc_inject;

  data_bus_arbiter #(.ADDR_W(32), .DATA_W(8), .ACCESS_CYCLES(AC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m0_req        (m0_req),
    .m0_rw         (cmd_rw[0]),
    .m0_len        (cmd_len[0]),
    .m0_addr       (cmd_addr[0]),
    .m0_wdata      (cmd_wdata[0]),
    .m0_gnt        (m0_gnt),
    .m0_ack        (m0_ack),
    .m0_rdata      (m0_rdata),
    .m0_err        (m0_err),
    .m1_req        (m1_req),
    .m1_rw         (cmd_rw[1]),
    .m1_len        (cmd_len[1]),
    .m1_addr       (cmd_addr[1]),
    .m1_wdata      (cmd_wdata[1]),
    .m1_gnt        (m1_gnt),
    .m1_ack        (m1_ack),
    .m1_rdata      (m1_rdata),
    .m1_err        (m1_err),
    .bus_rw        (bus_rw),
    .bus_len       (bus_len),
    .bus_addr      (bus_addr),
    .bus_write     (bus_write),
    .bus_read      (bus_read),
    .bus_exception (bus_exception)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic modelPick(input logic a0, input logic a1);
`ifdef ARB_ROUND_ROBIN_EN
    if (a0 && a1) return !model_last;
`else
    if (a0) return 1'b0;
`endif
    return a1;
  endfunction

  task automatic setCmd(input int n, input logic rw, input logic [1:0] len,
                        input logic [31:0] addr, input logic [7:0] wdata);
    cmd_rw[n]    = rw;
    cmd_len[n]   = len;
    cmd_addr[n]  = addr;
    cmd_wdata[n] = wdata;
  endtask

  // Predicts the grant order, raises the requests, and waits for the acks.
  // Without hold, a requester drops req and scrambles its command once granted.
  task automatic applyStimulus(input logic r0, input logic r1, input logic hold,
                               input int ntrans, input logic exc);
    logic a0, a1, o;
    exp_t e;
    int   acks, cyc;
    a0 = r0;
    a1 = r1;
    exc_inject = exc;
    for (int i = 0; i < ntrans; i++) begin
      o       = modelPick(a0, a1);
      e.owner = o;
      e.rw    = cmd_rw[o];
      e.len   = cmd_len[o];
      e.addr  = cmd_addr[o];
      e.wdata = cmd_wdata[o];
      e.rdata = cmd_addr[o][7:0] ^ 8'hB5;
      e.err   = exc;
      sb.push_back(e);
`ifdef ARB_ROUND_ROBIN_EN
      model_last = o;
`endif
      if (!hold) begin
        if (o) a1 = 1'b0;
        else   a0 = 1'b0;
      end
    end
    @(posedge clk); #1;
    m0_req = r0;
    m1_req = r1;
    acks = 0;
    cyc  = 0;
    while (acks < ntrans && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (m0_ack || m1_ack) begin
        if (acks == 0) checkOutput("ack_latency", 64'(cyc), 64'(AC + 2));
        acks++;
      end
      @(posedge clk); #1;
      if (!hold && m0_gnt && m0_req) begin
        m0_req      = 1'b0;
        cmd_addr[0] = ~cmd_addr[0];
        cmd_wdata[0] = ~cmd_wdata[0];
      end
      if (!hold && m1_gnt && m1_req) begin
        m1_req      = 1'b0;
        cmd_addr[1] = ~cmd_addr[1];
        cmd_wdata[1] = ~cmd_wdata[1];
      end
      if (acks == ntrans) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
    end
    checkOutput("stim_done", 64'(acks), 64'(ntrans));
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Cycle monitor: command/grant against the scoreboard head, acks pop it,
  // and both requesters' read-back outputs are compared every cycle.
  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      gnt_cnt  = 0;
      prev_ack = 1'b0;
      if (!rst_n) begin
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        exp_err[0]   = 1'b0;
        exp_err[1]   = 1'b0;
      end
    end else begin
      checkOutput("gnt_excl", 64'(m0_gnt & m1_gnt), 64'(0));
      if (m0_gnt || m1_gnt) begin
        checkOutput("idle_gap", 64'(prev_ack), 64'(0));
        if (sb.size() == 0) begin
          checkOutput("gnt_spurious", 64'(m0_gnt | m1_gnt), 64'(0));
        end else begin
          checkOutput("gnt_owner", 64'(m1_gnt), 64'(sb[0].owner));
          checkOutput("bus_cmd", 64'({bus_rw, bus_len, bus_addr, bus_write}),
                      64'({sb[0].rw, sb[0].len, sb[0].addr, sb[0].wdata}));
          gnt_cnt++;
        end
      end else begin
        checkOutput("bus_idle", 64'({bus_rw, bus_len, bus_addr, bus_write}), 64'(0));
      end
      checkOutput("ack_excl", 64'(m0_ack & m1_ack), 64'(0));
      if (m0_ack || m1_ack) begin
        if (sb.size() == 0) begin
          checkOutput("ack_spurious", 64'(m0_ack | m1_ack), 64'(0));
        end else begin
          mon_e = sb.pop_front();
          checkOutput("ack_owner", 64'(m1_ack), 64'(mon_e.owner));
          checkOutput("gnt_len", 64'(gnt_cnt), 64'(AC));
          exp_rdata[mon_e.owner] = mon_e.rdata;
          exp_err[mon_e.owner]   = mon_e.err;
        end
        gnt_cnt = 0;
      end
      checkOutput("m0_rdata", 64'(m0_rdata), 64'(exp_rdata[0]));
      checkOutput("m0_err",   64'(m0_err),   64'(exp_err[0]));
      checkOutput("m1_rdata", 64'(m1_rdata), 64'(exp_rdata[1]));
      checkOutput("m1_err",   64'(m1_err),   64'(exp_err[1]));
      prev_ack = m0_ack | m1_ack;
    end
  end

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    m0_req     = 1'b0;
    m1_req     = 1'b0;
    exc_inject = 1'b0;
    mon_en     = 1'b0;
    model_last = 1'b1;
    setCmd(0, RW_READ, LEN_BYTE, 32'h0, 8'h0);
    setCmd(1, RW_READ, LEN_BYTE, 32'h0, 8'h0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_gnt_ack", 64'({m0_gnt, m1_gnt, m0_ack, m1_ack}), 64'(0));
    checkOutput("rst_rdata_err", 64'({m0_rdata, m1_rdata, m0_err, m1_err}), 64'(0));
    checkOutput("rst_bus", 64'({bus_rw, bus_len, bus_addr, bus_write}), 64'(0));
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    setCmd(0, RW_READ, LEN_BYTE, 32'h10, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1, 1'b0);

    setCmd(1, RW_WRITE, LEN_WORD, 32'h20, 8'h7F);
    applyStimulus(1'b0, 1'b1, 1'b0, 1, 1'b0);

    setCmd(0, RW_WRITE, LEN_HALF, 32'h104, 8'h3C);
    setCmd(1, RW_READ, LEN_BYTE, 32'h2F0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 2, 1'b0);

    setCmd(0, RW_READ, LEN_WORD, 32'h40, 8'h00);
    setCmd(1, RW_WRITE, LEN_BYTE, 32'h55, 8'hC3);
    applyStimulus(1'b1, 1'b1, 1'b1, 4, 1'b0);

    setCmd(0, RW_READ, LEN_BYTE, 32'h77, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1, 1'b1);
    setCmd(0, RW_READ, LEN_HALF, 32'h78, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1, 1'b0);

    // m0 was the last owner here, so a round-robin tie now goes to m1.
    setCmd(0, RW_WRITE, LEN_WORD, 32'h1000, 8'h11);
    setCmd(1, RW_WRITE, LEN_HALF, 32'h2000, 8'h22);
    applyStimulus(1'b1, 1'b1, 1'b0, 2, 1'b0);

    // Reset in the second access cycle of an m0 transaction; the aborted
    // transaction must never ack and the tie-break history must be reset.
    mon_en = 1'b0;
    setCmd(0, RW_READ, LEN_BYTE, 32'h33, 8'h00);
    @(posedge clk); #1;
    m0_req = 1'b1;
    @(posedge clk); #1;
    m0_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_gnt", 64'(m0_gnt), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_gnt_ack", 64'({m0_gnt, m1_gnt, m0_ack, m1_ack}), 64'(0));
    checkOutput("abort_rdata_err", 64'({m0_rdata, m1_rdata, m0_err, m1_err}), 64'(0));
    checkOutput("abort_bus", 64'({bus_rw, bus_len, bus_addr, bus_write}), 64'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("abort_no_ack", 64'({m0_ack, m1_ack}), 64'(0));
    end
    sb.delete();
    model_last = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    setCmd(0, RW_READ, LEN_WORD, 32'h3C0, 8'h00);
    setCmd(1, RW_READ, LEN_BYTE, 32'h3D0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 2, 1'b0);

    checkOutput("sb_empty", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
